// File: rtl/fft_stream_ctrl.sv
// Frame controller around an external FFT core: gathers N input samples, starts the FFT,
// waits a bounded time for its result, then streams the N bins out in index order.
module fft_stream_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic signed [31:0]   i_s_data_r,
    input  logic signed [31:0]   i_s_data_i,
    output logic signed [31:0]   o_fft_data_in_r [0:N-1],
    output logic signed [31:0]   o_fft_data_in_i [0:N-1],
    output logic                 o_fft_valid,
    input  logic signed [31:0]   i_fft_data_out_r [0:N-1],
    input  logic signed [31:0]   i_fft_data_out_i [0:N-1],
    input  logic                 i_fft_ready,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic signed [31:0]   o_m_data_r,
    output logic signed [31:0]   o_m_data_i,
    output logic [$clog2(N)-1:0] o_m_index,
    output logic                 o_m_last,
    output logic                 o_busy,
    output logic                 o_err_timeout,
    output logic [15:0]          o_frame_cnt
);
    localparam int IW = $clog2(N);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [IW-1:0]      r_wrIdx;
    logic [IW-1:0]      r_rdIdx;
    logic [TW-1:0]      r_toCnt;
    logic [15:0]        r_frameCnt;
    logic               r_errTimeout;
    logic signed [31:0] r_inBufR  [0:N-1];
    logic signed [31:0] r_inBufI  [0:N-1];
    logic signed [31:0] r_outBufR [0:N-1];
    logic signed [31:0] r_outBufI [0:N-1];

    logic w_inFire;
    logic w_fftDone;

    assign w_inFire  = (r_state == ST_FILL) && i_s_valid;
    assign w_fftDone = (r_state == ST_WAIT) && i_fft_ready;

    // Buffers carry no reset; their contents only matter after a full write.
    always_ff @(posedge i_clk) begin
        if (w_inFire) begin
            r_inBufR[r_wrIdx] <= i_s_data_r;
            r_inBufI[r_wrIdx] <= i_s_data_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fftDone) begin
            for (int k = 0; k < N; k++) begin
                r_outBufR[k] <= i_fft_data_out_r[k];
                r_outBufI[k] <= i_fft_data_out_i[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_FILL;
            r_wrIdx      <= '0;
            r_rdIdx      <= '0;
            r_toCnt      <= '0;
            r_frameCnt   <= 16'd0;
            r_errTimeout <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (i_s_valid) begin
                        if (r_wrIdx == LAST_IDX) begin
                            r_wrIdx <= '0;
                            r_state <= ST_START;
                        end else begin
                            r_wrIdx <= r_wrIdx + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_toCnt <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the final allowed cycle still wins over the timeout.
                    if (i_fft_ready) begin
                        r_rdIdx <= '0;
                        r_state <= ST_DRAIN;
                    end else if (r_toCnt == TO_LAST) begin
                        r_errTimeout <= 1'b1;
                        r_state      <= ST_FILL;
                    end else begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (i_m_ready) begin
                        if (r_rdIdx == LAST_IDX) begin
                            r_rdIdx    <= '0;
                            r_frameCnt <= r_frameCnt + 16'd1;
                            r_state    <= ST_FILL;
                        end else begin
                            r_rdIdx <= r_rdIdx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // Handshake outputs are masked while reset is held so nothing leaks before the reset edge.
    assign o_s_ready     = !i_rst && (r_state == ST_FILL);
    assign o_fft_valid   = !i_rst && (r_state == ST_START);
    assign o_m_valid     = !i_rst && (r_state == ST_DRAIN);
    assign o_m_index     = o_m_valid ? r_rdIdx : '0;
    assign o_m_last      = o_m_valid && (r_rdIdx == LAST_IDX);
    assign o_m_data_r    = r_outBufR[r_rdIdx];
    assign o_m_data_i    = r_outBufI[r_rdIdx];
    assign o_busy        = !((r_state == ST_FILL) && (r_wrIdx == '0));
    assign o_err_timeout = r_errTimeout;
    assign o_frame_cnt   = r_frameCnt;

    assign o_fft_data_in_r = r_inBufR;
    assign o_fft_data_in_i = r_inBufI;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl: queue-based frame model plus an FFT stub that
// answers with suffix sums of the frame, exercised by directed and randomized scenarios.
module tb_fft_stream_ctrl;
    localparam int N       = 8;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               sValid;
    logic               sReady;
    logic signed [31:0] sDataR, sDataI;
    logic signed [31:0] fftInR  [0:N-1];
    logic signed [31:0] fftInI  [0:N-1];
    logic               fftValid;
    logic signed [31:0] fftOutR [0:N-1];
    logic signed [31:0] fftOutI [0:N-1];
    logic               fftReady;
    logic               mValid;
    logic               mReady;
    logic signed [31:0] mDataR, mDataI;
    logic [IW-1:0]      mIndex;
    logic               mLast;
    logic               busy;
    logic               errTimeout;
    logic [15:0]        frameCnt;

    fft_stream_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_valid(sValid), .o_s_ready(sReady),
        .i_s_data_r(sDataR), .i_s_data_i(sDataI),
        .o_fft_data_in_r(fftInR), .o_fft_data_in_i(fftInI),
        .o_fft_valid(fftValid),
        .i_fft_data_out_r(fftOutR), .i_fft_data_out_i(fftOutI),
        .i_fft_ready(fftReady),
        .o_m_valid(mValid), .i_m_ready(mReady),
        .o_m_data_r(mDataR), .o_m_data_i(mDataI),
        .o_m_index(mIndex), .o_m_last(mLast),
        .o_busy(busy), .o_err_timeout(errTimeout), .o_frame_cnt(frameCnt)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: the frame being gathered, the bins still to be drained, flags.
    logic signed [31:0] frameR[$], frameI[$];
    logic signed [31:0] drainR[$], drainI[$];
    bit  startPending = 0;
    bit  waiting      = 0;
    int  waitCycles   = 0;
    int  modelFrames  = 0;
    bit  modelErr     = 0;
    int  modelEvents  = 0;

    // Scenario knobs
    int  rstCycles   = 0;
    int  sMode       = 0;
    bit  toggleBit   = 0;
    bit  rampData    = 1;
    bit  mReadyRand  = 0;
    int  fftDelay    = 3;
    bit  spurious    = 0;
    bit  soak        = 0;
    bit  literalRamp = 0;
    int  stallAt     = -1;
    bit  stallDone   = 0;
    int  stallLeft   = 0;
    int  fftPulses   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit filling();
        return !startPending && !waiting && (drainR.size() == 0);
    endfunction

    task automatic applyStimulus();
        logic signed [31:0] sr, si;
        rst = (rstCycles > 0);
        if (rstCycles > 0) rstCycles--;

        toggleBit = ~toggleBit;
        case (sMode)
            0:       sValid = 1'b1;
            1:       sValid = toggleBit;
            default: sValid = 1'($urandom_range(0, 1));
        endcase
        if (rampData) begin
            sDataR = 32'(frameR.size() << 12);
            sDataI = 32'd0;
        end else begin
            sDataR = $urandom;
            sDataI = $urandom;
        end

        if (stallAt >= 0 && !stallDone && drainR.size() > 0 && (N - drainR.size()) == stallAt) begin
            stallLeft = 5;
            stallDone = 1;
        end
        if (stallLeft > 0) begin
            mReady = 1'b0;
            stallLeft--;
        end else begin
            mReady = mReadyRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        if (soak && startPending) fftDelay = $urandom_range(1, 12);

        for (int k = 0; k < N; k++) begin
            fftOutR[k] = $urandom;
            fftOutI[k] = $urandom;
        end
        if (waiting) begin
            fftReady = (fftDelay > 0) && (waitCycles == fftDelay - 1);
            if (fftReady) begin
                for (int k = 0; k < N; k++) begin
                    sr = 32'sd0;
                    si = 32'(k);
                    for (int j = k; j < N; j++) begin
                        sr = sr + frameR[j];
                        si = si + frameI[j];
                    end
                    fftOutR[k] = sr;
                    fftOutI[k] = si;
                end
            end
        end else begin
            fftReady = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic modelUpdate();
        if (rst) begin
            frameR.delete(); frameI.delete();
            drainR.delete(); drainI.delete();
            startPending = 0;
            waiting      = 0;
            modelFrames  = 0;
            modelErr     = 0;
        end else if (drainR.size() > 0) begin
            if (mReady) begin
                void'(drainR.pop_front());
                void'(drainI.pop_front());
                if (drainR.size() == 0) begin
                    modelFrames = (modelFrames + 1) % 65536;
                    modelEvents++;
                end
            end
        end else if (waiting) begin
            if (fftReady) begin
                for (int k = 0; k < N; k++) begin
                    drainR.push_back(fftOutR[k]);
                    drainI.push_back(fftOutI[k]);
                end
                frameR.delete(); frameI.delete();
                waiting = 0;
            end else if (waitCycles == TIMEOUT - 1) begin
                modelErr = 1;
                frameR.delete(); frameI.delete();
                waiting = 0;
                modelEvents++;
            end else begin
                waitCycles++;
            end
        end else if (startPending) begin
            startPending = 0;
            waiting      = 1;
            waitCycles   = 0;
        end else if (sValid) begin
            frameR.push_back(sDataR);
            frameI.push_back(sDataI);
            if (frameR.size() == N) startPending = 1;
        end
    endtask

    task automatic checkOutput();
        bit drainActive;
        drainActive = !rst && (drainR.size() > 0);
        if (fftValid === 1'b1) fftPulses++;

        chk("s_ready", sReady, !rst && filling());
        chk("fft_valid", fftValid, !rst && startPending);
        chk("m_valid", mValid, drainActive);
        if (drainActive) begin
            chk("m_data_r", mDataR, drainR[0]);
            chk("m_data_i", mDataI, drainI[0]);
            chk("m_index", mIndex, 64'(N - drainR.size()));
            chk("m_last", mLast, drainR.size() == 1);
            if (literalRamp && drainR.size() == N) chk("ramp_bin0_r", mDataR, 64'h1C000);
        end else begin
            chk("m_index_idle", mIndex, 64'd0);
            chk("m_last_idle", mLast, 64'd0);
        end
        chk("busy", busy, !(filling() && frameR.size() == 0));
        chk("err_timeout", errTimeout, modelErr);
        chk("frame_cnt", frameCnt, 64'(modelFrames));
        if (!rst && (startPending || waiting)) begin
            for (int i = 0; i < N; i++) begin
                chk("fft_data_in_r", fftInR[i], frameR[i]);
                chk("fft_data_in_i", fftInI[i], frameI[i]);
                if (literalRamp && startPending) chk("ramp_fft_in_r", fftInR[i], 64'(i << 12));
            end
        end
    endtask

    task automatic cycleOnce();
        applyStimulus();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runEvents(input int n, input int budget, input string tag);
        int target;
        int cyc;
        target = modelEvents + n;
        cyc = 0;
        while (modelEvents < target && cyc < budget) begin
            cycleOnce();
            cyc++;
        end
        checks++;
        if (modelEvents < target) begin
            errors++;
            $display("[TB] FAIL %s: cycle budget %0d expired, events %0d required %0d", tag, budget, modelEvents, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;

        rstCycles = 3;
        repeat (4) cycleOnce();
        chk("reset_s_ready", sReady, 64'd1);
        chk("reset_frame_cnt", frameCnt, 64'd0);

        $display("[TB] ramp frame");
        literalRamp = 1; fftPulses = 0;
        runEvents(1, 300, "ramp");
        chk("ramp_frame_cnt", frameCnt, 64'd1);
        chk("ramp_fft_pulses", 64'(fftPulses), 64'd1);

        $display("[TB] input gaps");
        sMode = 1; fftDelay = 5; spurious = 1; fftPulses = 0;
        runEvents(1, 300, "gaps");
        chk("gaps_fft_pulses", 64'(fftPulses), 64'd1);

        $display("[TB] backpressure");
        literalRamp = 0; rampData = 0; sMode = 0; stallAt = 3; stallDone = 0;
        runEvents(1, 300, "backpressure");
        stallAt = -1;

        $display("[TB] result on last allowed wait cycle");
        fftDelay = TIMEOUT;
        runEvents(1, 300, "late_ready");
        chk("late_ready_err", errTimeout, 64'd0);

        $display("[TB] timeout");
        fftDelay = 0;
        runEvents(1, 300, "timeout");
        chk("timeout_err", errTimeout, 64'd1);
        chk("timeout_frame_cnt", frameCnt, 64'd4);

        $display("[TB] reset mid-wait");
        cyc = 0;
        while (!(waiting && waitCycles == 10) && cyc < 300) begin cycleOnce(); cyc++; end
        chk("reach_mid_wait", 64'(waiting && waitCycles == 10), 64'd1);
        rstCycles = 1;
        cycleOnce();
        rampData = 1; literalRamp = 1; fftDelay = 3; spurious = 0;
        runEvents(1, 300, "ramp_after_wait_reset");
        chk("post_wait_reset_frame_cnt", frameCnt, 64'd1);
        chk("post_wait_reset_err", errTimeout, 64'd0);

        $display("[TB] reset mid-drain");
        literalRamp = 0; rampData = 0; mReadyRand = 1;
        cyc = 0;
        while (!(drainR.size() > 0 && (N - drainR.size()) == 4) && cyc < 300) begin cycleOnce(); cyc++; end
        chk("reach_mid_drain", 64'(drainR.size() == N - 4), 64'd1);
        rstCycles = 1;
        cycleOnce();
        rampData = 1; literalRamp = 1; mReadyRand = 0;
        runEvents(1, 300, "ramp_after_drain_reset");
        chk("post_drain_reset_frame_cnt", frameCnt, 64'd1);

        $display("[TB] randomized soak");
        literalRamp = 0; rampData = 0; sMode = 2; mReadyRand = 1; spurious = 1; soak = 1;
        runEvents(8, 4000, "soak");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
